// File: rtl/sar_search.sv
// Signed successive-approximation search engine: drives TRIAL into an external
// signed less-than comparator and resolves the target one bit per trial from LT.
// Ports: CLK/RESET (async, active-high), START (accepted in IDLE only), LT (target < TRIAL),
//        TRIAL (operand to comparator), BUSY (search in progress), DONE (1-cycle result
//        pulse), O (result, held until next DONE).
// Latency: DONE in cycle N+1 after the START edge (2N+1 with SAR_SETTLE_EN defined, where
// each trial is held two cycles and LT is sampled only at the end of the second).
// Backpressure: none; START while BUSY or DONE is dropped, not queued.
module sar_search #(
    parameter int N = 4
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         START,
    input  logic         LT,
    output logic [N-1:0] TRIAL,
    output logic         BUSY,
    output logic         DONE,
    output logic [N-1:0] O
);
    localparam int KW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  u, u_nxt;       // offset-binary trial; TRIAL is u with MSB flipped
    logic [KW-1:0] k, k_nxt;       // bit currently being decided
    logic [N-1:0]  o_nxt;
    logic          resolve;        // high in the cycle whose edge commits bit k

`ifdef SAR_SETTLE_EN
    logic phase, phase_nxt;        // 0: settle cycle, 1: sample cycle

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) phase <= 1'b0;
        else       phase <= phase_nxt;
    end

    assign resolve = phase;
`else
    assign resolve = 1'b1;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            u     <= '0;
            k     <= '0;
            O     <= '0;
        end else begin
            state <= state_nxt;
            u     <= u_nxt;
            k     <= k_nxt;
            O     <= o_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        u_nxt     = u;
        k_nxt     = k;
        o_nxt     = O;
`ifdef SAR_SETTLE_EN
        phase_nxt = phase;
`endif
        case (state)
            IDLE: begin
                if (START) begin
                    u_nxt     = {1'b1, {(N-1){1'b0}}};
                    k_nxt     = KW'(N - 1);
                    state_nxt = STEP;
`ifdef SAR_SETTLE_EN
                    phase_nxt = 1'b0;
`endif
                end
            end
            STEP: begin
`ifdef SAR_SETTLE_EN
                phase_nxt = ~phase;
`endif
                if (resolve) begin
                    // Drop bit k if the target is below the trial, then tentatively
                    // set the next lower bit for the following trial.
                    for (int i = 0; i < N; i++) begin
                        if (i == int'(k) && LT) u_nxt[i] = 1'b0;
                        if (i + 1 == int'(k))   u_nxt[i] = 1'b1;
                    end
                    if (k == '0) begin
                        // O is captured on the edge entering FIN, from the final u.
                        state_nxt = FIN;
                        o_nxt     = {~u_nxt[N-1], u_nxt[N-2:0]};
                    end else begin
                        k_nxt = k - KW'(1);
                    end
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign TRIAL = {~u[N-1], u[N-2:0]};
    assign BUSY  = (state == STEP);
    assign DONE  = (state == FIN);

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search (N=4): comparator modelled as LT = target < TRIAL; a scoreboard
// queue holds expected TRIAL values and results, checked by an independent monitor.
// Works in the default build and with SAR_SETTLE_EN (LT glitched in settle cycles).
module tb_sar_search;
    localparam int N = 4;
`ifdef SAR_SETTLE_EN
    localparam int TPC = 2;
`else
    localparam int TPC = 1;
`endif
    localparam int LAT = N * TPC + 1;

    logic                CLK = 1'b0;
    logic                RESET = 1'b0;
    logic                START = 1'b0;
    logic                LT;
    logic [N-1:0]        TRIAL;
    logic                BUSY;
    logic                DONE;
    logic [N-1:0]        O;
    logic signed [N-1:0] target = '0;
    logic                glitch_on = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;
    int gcyc   = 0;
    int start_cyc = 0;
    int exp_trial[$];
    int exp_o[$];
    int busy_cnt = 0;
    int o_hold = 0;

    sar_search #(.N(N)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .LT(LT),
        .TRIAL(TRIAL), .BUSY(BUSY), .DONE(DONE), .O(O)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) gcyc <= gcyc + 1;

    // Comparator model; in settle builds the first cycle of each trial sees an inverted flag.
    assign LT = (target < $signed(TRIAL)) ^
                (glitch_on && BUSY && (((gcyc - start_cyc) % 2) == 1));

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference binary search over a signed range, using plain arithmetic.
    function automatic void ref_search(input int tgt, output int tr[N], output int o);
        int t;
        int step;
        t    = 0;
        step = 1 << (N - 2);
        o    = 0;
        for (int i = 0; i < N; i++) begin
            tr[i] = t;
            if (i == N - 1) begin
                o = (tgt < t) ? t - 1 : t;
            end else begin
                if (tgt < t) t = t - step;
                else         t = t + step;
                step = step / 2;
            end
        end
    endfunction

    // Monitor: consumes expectations whenever the DUT presents a trial or a result.
    always @(negedge CLK) begin
        if (RESET) begin
            busy_cnt = 0;
            o_hold   = 0;
        end else begin
            if (BUSY) begin
                busy_cnt++;
                if (exp_trial.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_trial: got %0d expected none", $signed(TRIAL));
                end else begin
                    chk("trial", int'($signed(TRIAL)), exp_trial.pop_front());
                end
            end
            if (DONE) begin
                if (exp_o.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_done: got O=%0d expected no DONE", $signed(O));
                end else begin
                    chk("result_o", int'($signed(O)), exp_o.pop_front());
                end
                chk("busy_at_done", int'(BUSY), 0);
                chk("busy_cycles", busy_cnt, N * TPC);
                chk("trials_left", exp_trial.size(), 0);
                busy_cnt = 0;
                o_hold   = int'($signed(O));
            end else begin
                chk("o_stable", int'($signed(O)), o_hold);
            end
        end
    end

    // Issue one search; returns at the negedge of the DONE cycle (or after hold checks).
    task automatic run_search(input int tgt, input int tr[N], input int o, input bit hold);
        bit seen;
        @(negedge CLK);
        target = tgt[N-1:0];
        for (int i = 0; i < N; i++)
            for (int j = 0; j < TPC; j++) exp_trial.push_back(tr[i]);
        exp_o.push_back(o);
        start_cyc = gcyc;
        START = 1'b1;
        @(posedge CLK);
        if (!hold) #1 START = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge CLK);
            if (DONE) seen = 1'b1;
        end
        if (!seen) begin
            n_chk++; n_fail++;
            $display("FAIL done_timeout: got no DONE expected DONE in cycle %0d", LAT);
        end else begin
            chk("done_cycle", gcyc - start_cyc, LAT);
        end
        if (hold) begin
            @(posedge CLK);
            #1 START = 1'b0;
            @(negedge CLK);
            chk("idle_after_held_start", int'(BUSY), 0);
        end
    endtask

    int tr[N];
    int ro;
    int prev_start;

    initial begin
`ifdef SAR_SETTLE_EN
        glitch_on = 1'b1;
`endif
        #1 RESET = 1'b1;
        #2;
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_done", int'(DONE), 0);
        chk("rst_o", int'($signed(O)), 0);
        chk("rst_trial", int'($signed(TRIAL)), -8);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #2 RESET = 1'b0;

        run_search(-3, '{0, -4, -2, -3}, -3, 1'b0);
        run_search(7,  '{0, 4, 6, 7},    7,  1'b0);
        run_search(-8, '{0, -4, -6, -7}, -8, 1'b0);
        @(negedge CLK);
        chk("idle_trial_eq_o", int'($signed(TRIAL)), int'($signed(O)));

        // START held through the whole search and its FIN cycle.
        run_search(2, '{0, 4, 2, 3}, 2, 1'b1);

        // Back-to-back sweep: each START lands on the first IDLE cycle.
        prev_start = 0;
        for (int tg = -8; tg <= 7; tg++) begin
            ref_search(tg, tr, ro);
            chk("ref_model", ro, tg);
            run_search(tg, tr, ro, 1'b0);
            if (tg > -8) chk("sweep_period", start_cyc - prev_start, LAT + 1);
            prev_start = start_cyc;
        end

        // Asynchronous reset in the middle of cycle 2 of a search for 6.
        run_search(-1, '{0, -4, -2, -1}, -1, 1'b0);
        @(negedge CLK);
        target = 6;
        exp_trial.push_back(0);
        for (int j = 1; j < TPC; j++) exp_trial.push_back(0);
        START = 1'b1;
        start_cyc = gcyc;
        @(posedge CLK);
        #1 START = 1'b0;
        @(posedge CLK);
        #3 RESET = 1'b1;
        exp_trial.delete();
        exp_o.delete();
        #1;
        chk("mid_rst_busy", int'(BUSY), 0);
        chk("mid_rst_done", int'(DONE), 0);
        chk("mid_rst_o", int'($signed(O)), 0);
        chk("mid_rst_trial", int'($signed(TRIAL)), -8);
        @(negedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        #2 RESET = 1'b0;
        run_search(5, '{0, 4, 6, 5}, 5, 1'b0);

        repeat (3) @(negedge CLK);
        chk("no_pending_results", exp_o.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
